top_countdown: RTL and testbench

TOP_COUNTDOWN -- requirements
Module: top_countdown

---
 rtl/top_countdown.sv | 185 ++++++++++++++++++
 tb/tb_top_countdown.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_countdown.sv
// top_countdown: mm:ss:cc countdown timer with debounced buttons and active-low seven-segment digits.
// Optional feature macro: TOP_COUNTDOWN_BLINK_EN (2 Hz blanking of all digits while in ALARM).
module top_countdown #(
    parameter int CLK_PER_MS = 50000,
    parameter int MS_PER_CS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       clear,
    output logic [6:0] m10,
    output logic [6:0] m1,
    output logic [6:0] s10,
    output logic [6:0] s1,
    output logic [6:0] c10,
    output logic [6:0] c1,
    output logic       alarm,
    output logic       running,
    output logic [1:0] state_dbg
);
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int CW = (MS_PER_CS > 1) ? $clog2(MS_PER_CS) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [CW-1:0] CS_LAST = CW'(MS_PER_CS - 1);

    typedef enum logic [1:0] {ST_SET, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ps_q, ps_d;
    logic [CW-1:0]   cs_q, cs_d;
    logic [3:0]      meta_q, meta_d, sync_q, sync_d, prev_q, prev_d;
    logic [5:0][3:0] val_q, val_d, val_dec;
    logic            ms_tick, borrow, blank;
    logic            clr_p, ss_p, min_p, sec_p;

    function automatic logic [7:0] inc59(input logic [3:0] tens, input logic [3:0] ones);
        if (ones != 4'd9)      return {tens, ones + 4'd1};
        else if (tens != 4'd5) return {tens + 4'd1, 4'd0};
        else                   return 8'd0;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Button order in all vectors: {clear, start_stop, inc_min, inc_sec}.
    always_comb begin
        ms_tick = (ps_q == PS_LAST);
        ps_d    = ms_tick ? '0 : ps_q + 1'b1;
        meta_d  = {clear, start_stop, inc_min, inc_sec};
        sync_d  = meta_q;
        prev_d  = ms_tick ? sync_q : prev_q;
        {clr_p, ss_p, min_p, sec_p} = ms_tick ? (sync_q & ~prev_q) : 4'b0000;
    end

    // Borrow chain: c1, c10 wrap to 9 / 9, s10 and m10 digits wrap to 5.
    always_comb begin
        val_dec = val_q;
        borrow  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (val_q[i] != 4'd0) begin
                    val_dec[i] = val_q[i] - 4'd1;
                    borrow     = 1'b0;
                end else begin
                    val_dec[i] = (i == 3 || i == 5) ? 4'd5 : 4'd9;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        cs_d    = cs_q;
        if (ms_tick) begin
            if (clr_p) begin
                state_d = ST_SET;
                val_d   = '0;
                cs_d    = '0;
            end else begin
                case (state_q)
                    ST_SET: begin
                        if (ss_p) begin
                            if (val_q != '0) state_d = ST_RUN;
                        end else begin
                            if (min_p) {val_d[5], val_d[4]} = inc59(val_q[5], val_q[4]);
                            if (sec_p) {val_d[3], val_d[2]} = inc59(val_q[3], val_q[2]);
                        end
                    end
                    ST_RUN: begin
                        if (cs_q == CS_LAST) begin
                            cs_d  = '0;
                            val_d = val_dec;
                            if (val_dec == '0) state_d = ST_ALARM;
                            else if (ss_p)     state_d = ST_PAUSE;
                        end else if (ss_p) begin
                            state_d = ST_PAUSE;
                        end else begin
                            cs_d = cs_q + 1'b1;
                        end
                    end
                    ST_PAUSE: begin
                        if (ss_p) state_d = ST_RUN;
                    end
                    ST_ALARM: begin
                        if (ss_p) begin
                            state_d = ST_SET;
                            cs_d    = '0;
                        end
                    end
                    default: state_d = ST_SET;
                endcase
            end
        end
    end

`ifdef TOP_COUNTDOWN_BLINK_EN
    logic [8:0] blink_q, blink_d;

    // Held at zero outside ALARM, so every entry into ALARM starts a fresh blink period.
    always_comb begin
        blink_d = blink_q;
        if (state_q != ST_ALARM) blink_d = '0;
        else if (ms_tick)        blink_d = (blink_q == 9'd499) ? '0 : blink_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) blink_q <= '0;
        else      blink_q <= blink_d;
    end

    assign blank = (state_q == ST_ALARM) && (blink_q >= 9'd250);
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_SET;
            ps_q    <= '0;
            cs_q    <= '0;
            meta_q  <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            cs_q    <= cs_d;
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        m10 = blank ? 7'b1111111 : seg7(val_q[5]);
        m1  = blank ? 7'b1111111 : seg7(val_q[4]);
        s10 = blank ? 7'b1111111 : seg7(val_q[3]);
        s1  = blank ? 7'b1111111 : seg7(val_q[2]);
        c10 = blank ? 7'b1111111 : seg7(val_q[1]);
        c1  = blank ? 7'b1111111 : seg7(val_q[0]);
    end

    assign alarm     = (state_q == ST_ALARM);
    assign running   = (state_q == ST_RUN);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_top_countdown.sv
// tb_top_countdown: directed vector table plus hand sequences for run, pause, alarm, wrap and reset.
module tb_top_countdown;
    localparam logic [3:0] B_SEC = 4'b0001;
    localparam logic [3:0] B_MIN = 4'b0010;
    localparam logic [3:0] B_SS  = 4'b0100;
    localparam logic [3:0] B_CLR = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_stop = 1'b0, inc_min = 1'b0, inc_sec = 1'b0, clear = 1'b0;
    logic [6:0] m10, m1, s10, s1, c10, c1;
    logic       alarm, running;
    logic [1:0] state_dbg;
    logic [41:0] dig;
    int         n_vec = 0;
    int         n_miss = 0;

    typedef struct {
        logic [3:0]  btn;
        logic [23:0] val;
        logic        run;
        logic        alm;
    } vec_t;

    vec_t vecs[9];

    top_countdown #(.CLK_PER_MS(4), .MS_PER_CS(2)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .inc_min(inc_min),
        .inc_sec(inc_sec), .clear(clear), .m10(m10), .m1(m1), .s10(s10),
        .s1(s1), .c10(c10), .c1(c1), .alarm(alarm), .running(running),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    assign dig = {m10, m1, s10, s1, c10, c1};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h7f;
        endcase
    endfunction

    function automatic logic [41:0] segs(input logic [23:0] v);
        return {seg(v[23:20]), seg(v[19:16]), seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
    endfunction

    task automatic set_btn(input logic [3:0] b);
        {clear, start_stop, inc_min, inc_sec} = b;
    endtask

    task automatic press(input logic [3:0] b);
        set_btn(b);
        repeat (12) @(negedge clk);
        set_btn(4'b0000);
        repeat (12) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [23:0] v, input logic r, input logic a);
        n_vec++;
        if ({dig, running, alarm} !== {segs(v), r, a}) begin
            n_miss++;
            $display("FAIL %s: got digits=%h run=%b alarm=%b, expected value %h digits=%h run=%b alarm=%b",
                     name, dig, running, alarm, v, segs(v), r, a);
        end
    endtask

    task automatic wait_run(input string name, input logic r, input int budget);
        int n = 0;
        while (running !== r && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (running !== r) begin
            n_miss++;
            $display("FAIL %s: running=%b after %0d cycles, expected %b", name, running, n, r);
        end
    endtask

    task automatic wait_val(input string name, input logic [23:0] v, input int budget);
        int n = 0;
        while (dig !== segs(v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (dig !== segs(v)) begin
            n_miss++;
            $display("FAIL %s: digits=%h after %0d cycles, expected value %h", name, dig, n, v);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{4'b0000,        24'h000000, 1'b0, 1'b0};
        vecs[1] = '{B_SS,           24'h000000, 1'b0, 1'b0};
        vecs[2] = '{B_SEC,          24'h000100, 1'b0, 1'b0};
        vecs[3] = '{B_SEC,          24'h000200, 1'b0, 1'b0};
        vecs[4] = '{B_MIN,          24'h010200, 1'b0, 1'b0};
        vecs[5] = '{B_MIN | B_SEC,  24'h020300, 1'b0, 1'b0};
        vecs[6] = '{B_CLR,          24'h000000, 1'b0, 1'b0};
        vecs[7] = '{B_SEC,          24'h000100, 1'b0, 1'b0};
        vecs[8] = '{B_CLR | B_SS | B_SEC, 24'h000000, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].btn != 4'b0000) press(vecs[i].btn);
            check($sformatf("vec%0d", i), vecs[i].val, vecs[i].run, vecs[i].alm);
        end

        // Start and first centisecond decrement.
        press(B_SEC); press(B_SEC); press(B_SEC); press(B_MIN);
        check("set_010300", 24'h010300, 1'b0, 1'b0);
        set_btn(B_SS);
        wait_run("run_start", 1'b1, 20);
        check("run_entry", 24'h010300, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("first_cs_tick", 24'h010299, 1'b1, 1'b0);
        set_btn(4'b0000);
        press(B_CLR);
        check("clear_in_run", 24'h000000, 1'b0, 1'b0);

        // Seconds and minutes wrap without carry.
        press(B_MIN);
        for (int i = 1; i <= 60; i++) begin
            press(B_SEC);
            if (i == 59) check("sec_59", 24'h015900, 1'b0, 1'b0);
            if (i == 60) check("sec_wrap", 24'h010000, 1'b0, 1'b0);
        end
        for (int i = 1; i <= 59; i++) begin
            press(B_MIN);
            if (i == 58) check("min_59", 24'h590000, 1'b0, 1'b0);
            if (i == 59) check("min_wrap", 24'h000000, 1'b0, 1'b0);
        end

        // Countdown to alarm: 100 cs_ticks of 8 clocks each.
        press(B_SEC);
        check("set_000100", 24'h000100, 1'b0, 1'b0);
        set_btn(B_SS);
        wait_run("alarm_run_start", 1'b1, 20);
        set_btn(4'b0000);
        n = 0;
        while (alarm !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (n != 800) begin
            n_miss++;
            $display("FAIL alarm_latency: %0d cycles, expected 800", n);
        end
        check("alarm_entry", 24'h000000, 1'b0, 1'b1);
        repeat (1000) @(negedge clk);
`ifdef TOP_COUNTDOWN_BLINK_EN
        n_vec++;
        if ({dig, running, alarm} !== {{6{7'h7f}}, 1'b0, 1'b1}) begin
            n_miss++;
            $display("FAIL alarm_blank: got digits=%h run=%b alarm=%b, expected all 7f run=0 alarm=1",
                     dig, running, alarm);
        end
`else
        check("alarm_steady", 24'h000000, 1'b0, 1'b1);
`endif
        press(B_SS);
        check("alarm_ack", 24'h000000, 1'b0, 1'b0);

        // Pause holds value and cs count, resume continues.
        press(B_SEC); press(B_SEC); press(B_SEC); press(B_SEC); press(B_SEC);
        check("set_000500", 24'h000500, 1'b0, 1'b0);
        set_btn(B_SS);
        wait_run("pause_run_start", 1'b1, 20);
        set_btn(4'b0000);
        wait_val("reach_000495", 24'h000495, 60);
        set_btn(B_SS);
        wait_run("pause_enter", 1'b0, 20);
        set_btn(4'b0000);
        check("paused", 24'h000495, 1'b0, 1'b0);
        repeat (160) @(negedge clk);
        check("paused_frozen", 24'h000495, 1'b0, 1'b0);
        set_btn(B_SS);
        wait_run("resume", 1'b1, 20);
        check("resume_entry", 24'h000495, 1'b1, 1'b0);
        wait_val("resume_000494", 24'h000494, 16);
        set_btn(4'b0000);

        // Reset mid-run discards the count.
        repeat (20) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_async", 24'h000000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_release", 24'h000000, 1'b0, 1'b0);
        press(B_SEC);
        check("after_reset_set", 24'h000100, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
